// File: rtl/t09_score_controller.sv
// Game FSM for the snake datapath: turns collision pulses into BCD score, lives,
// a persistent high score and a one-cycle grow pulse for the body-length logic.
module t09_score_controller #(
   parameter logic [7:0]  MAX_SCORE = 8'h50,
   parameter logic [1:0]  LIVES     = 2'd3,
   parameter int unsigned OVER_HOLD = 8
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       start,
   input  logic       goodColl,
   input  logic       badColl,
   output logic [7:0] score_bcd,
   output logic [7:0] high_bcd,
   output logic [1:0] lives,
   output logic [1:0] state,
   output logic       playing,
   output logic       grow
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] WIN  = 2'd2;
   localparam logic [1:0] OVER = 2'd3;
   localparam logic [7:0] HOLD_INIT = 8'(OVER_HOLD);

   logic [7:0] holdCnt;
   logic [1:0] stateNxt;
   logic [7:0] scoreNxt;
   logic [7:0] highNxt;
   logic [7:0] holdNxt;
   logic [7:0] scoreInc;
   logic [1:0] livesNxt;
   logic       growNxt;

   // Packed-BCD increment, saturating at 99.
   function automatic logic [7:0] bcdInc(input logic [7:0] v);
      if (v == 8'h99)
         return v;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Valid packed BCD orders the same as plain unsigned.
   function automatic logic [7:0] bcdMax(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   always_comb begin
      stateNxt = state;
      scoreNxt = score_bcd;
      highNxt  = high_bcd;
      livesNxt = lives;
      holdNxt  = holdCnt;
      growNxt  = 1'b0;
      scoreInc = bcdInc(score_bcd);
      case (state)
         IDLE: begin
            if (start) begin
               stateNxt = RUN;
               scoreNxt = 8'h00;
               livesNxt = LIVES;
            end
         end
         RUN: begin
            if (badColl) begin
               if (lives <= 2'd1) begin
                  stateNxt = OVER;
                  livesNxt = 2'd0;
                  highNxt  = bcdMax(high_bcd, score_bcd);
                  holdNxt  = HOLD_INIT;
               end else begin
                  livesNxt = lives - 2'd1;
               end
            end else if (goodColl) begin
               scoreNxt = scoreInc;
               growNxt  = 1'b1;
               if (scoreInc == MAX_SCORE) begin
                  stateNxt = WIN;
                  highNxt  = bcdMax(high_bcd, scoreInc);
                  holdNxt  = HOLD_INIT;
               end
            end
         end
         default: begin
            // WIN/OVER: restart only once the hold has fully expired.
            if (holdCnt != 8'd0) begin
               holdNxt = holdCnt - 8'd1;
            end else if (start) begin
               stateNxt = RUN;
               scoreNxt = 8'h00;
               livesNxt = LIVES;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state     <= IDLE;
         score_bcd <= 8'h00;
         high_bcd  <= 8'h00;
         lives     <= 2'd0;
         holdCnt   <= 8'd0;
         grow      <= 1'b0;
         playing   <= 1'b0;
      end else begin
         state     <= stateNxt;
         score_bcd <= scoreNxt;
         high_bcd  <= highNxt;
         lives     <= livesNxt;
         holdCnt   <= holdNxt;
         grow      <= growNxt;
         playing   <= (stateNxt == RUN);
      end
   end

endmodule

// File: tb/tb_t09_score_controller.sv
// Directed bench for t09_score_controller: a decimal game model is compared every
// cycle, plus literal checks at the key points of each scenario.
module tb_t09_score_controller;

   localparam int MAX_DEC  = 50;
   localparam int LIVES0   = 3;
   localparam int HOLD     = 8;

   logic       clk;
   logic       nRst;
   logic       start;
   logic       goodColl;
   logic       badColl;
   logic [7:0] score_bcd;
   logic [7:0] high_bcd;
   logic [1:0] lives;
   logic [1:0] state;
   logic       playing;
   logic       grow;

   int errors = 0;
   int checks = 0;
   int growCount = 0;

   // Model: 0=IDLE 1=RUN 2=WIN 3=OVER, score and high kept in decimal.
   int mState = 0;
   int mScore = 0;
   int mHigh  = 0;
   int mLives = 0;
   int mHold  = 0;
   int mGrow  = 0;

   t09_score_controller #(
      .MAX_SCORE(8'h50),
      .LIVES(2'd3),
      .OVER_HOLD(HOLD)
   ) dut (
      .clk(clk),
      .nRst(nRst),
      .start(start),
      .goodColl(goodColl),
      .badColl(badColl),
      .score_bcd(score_bcd),
      .high_bcd(high_bcd),
      .lives(lives),
      .state(state),
      .playing(playing),
      .grow(grow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int toBcd(input int d);
      return ((d / 10) << 4) | (d % 10);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic endGame(input int st);
      if (mScore > mHigh)
         mHigh = mScore;
      mHold  = HOLD;
      mState = st;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge nRst);
         if (!nRst) begin
            mState = 0; mScore = 0; mHigh = 0; mLives = 0; mHold = 0; mGrow = 0;
         end else begin
            mGrow = 0;
            if (mState == 0) begin
               if (start) begin
                  mState = 1; mScore = 0; mLives = LIVES0;
               end
            end else if (mState == 1) begin
               if (badColl) begin
                  mLives = mLives - 1;
                  if (mLives == 0)
                     endGame(3);
               end else if (goodColl) begin
                  mScore = (mScore < 99) ? mScore + 1 : 99;
                  mGrow  = 1;
                  if (mScore == MAX_DEC)
                     endGame(2);
               end
            end else begin
               if (mHold > 0)
                  mHold = mHold - 1;
               else if (start) begin
                  mState = 1; mScore = 0; mLives = LIVES0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (grow === 1'b1)
            growCount++;
         check("cyc_score", int'(score_bcd), toBcd(mScore));
         check("cyc_high", int'(high_bcd), toBcd(mHigh));
         check("cyc_lives", int'(lives), mLives);
         check("cyc_state", int'(state), mState);
         check("cyc_playing", int'(playing), (mState == 1) ? 1 : 0);
         check("cyc_grow", int'(grow), mGrow);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      nRst = 1'b0;
      tick();
      tick();
      nRst = 1'b1;
      tick();
   endtask

   task automatic goods(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         goodColl = 1'b1;
         tick();
         goodColl = 1'b0;
         for (int j = 1; j < gap; j++)
            tick();
      end
   endtask

   task automatic bads(input int n);
      for (int i = 0; i < n; i++) begin
         badColl = 1'b1;
         tick();
         badColl = 1'b0;
         tick();
      end
   endtask

   task automatic startGame();
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state == 2'd1)
            break;
      end
      start = 1'b0;
      check("start_reached_run", int'(state), 1);
   endtask

   initial begin
      nRst = 1'b0; start = 1'b0; goodColl = 1'b0; badColl = 1'b0;
      tick();
      tick();
      check("rst_state", int'(state), 0);
      check("rst_score", int'(score_bcd), 0);
      check("rst_lives", int'(lives), 0);
      check("rst_playing", int'(playing), 0);
      nRst = 1'b1;
      tick();

      // Game start from IDLE
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_state", int'(state), 1);
      check("t1_lives", int'(lives), 3);
      check("t1_score", int'(score_bcd), 8'h00);
      check("t1_playing", int'(playing), 1);

      // Twelve spaced food pulses
      growCount = 0;
      goods(12, 3);
      check("t2_score", int'(score_bcd), 8'h12);
      check("t2_growcount", growCount, 12);

      // Simultaneous good+bad at score 05
      doReset();
      startGame();
      goods(5, 1);
      goodColl = 1'b1; badColl = 1'b1;
      tick();
      goodColl = 1'b0; badColl = 1'b0;
      check("t3_score", int'(score_bcd), 8'h05);
      check("t3_lives", int'(lives), 2);
      check("t3_grow", int'(grow), 0);

      // Game over at 07, hold window, restart
      doReset();
      startGame();
      goods(7, 2);
      badColl = 1'b1; tick(); badColl = 1'b0;
      badColl = 1'b1; tick(); badColl = 1'b0;
      badColl = 1'b1; tick(); badColl = 1'b0;
      check("t4_state_over", int'(state), 3);
      check("t4_high", int'(high_bcd), 8'h07);
      check("t4_lives", int'(lives), 0);
      tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_start_ignored", int'(state), 3);
      tick(); tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_restart_state", int'(state), 1);
      check("t4_restart_score", int'(score_bcd), 0);
      check("t4_restart_lives", int'(lives), 3);
      check("t4_high_kept", int'(high_bcd), 8'h07);

      // Win at 50, later pulses ignored
      goods(50, 1);
      check("t5_state_win", int'(state), 2);
      check("t5_score", int'(score_bcd), 8'h50);
      check("t5_high", int'(high_bcd), 8'h50);
      goods(3, 2);
      check("t5_score_frozen", int'(score_bcd), 8'h50);

      // Asynchronous reset mid-game
      startGame();
      goods(23, 1);
      check("t6_score_pre", int'(score_bcd), 8'h23);
      nRst = 1'b0;
      #1;
      check("t6_state", int'(state), 0);
      check("t6_score", int'(score_bcd), 0);
      check("t6_high", int'(high_bcd), 0);
      check("t6_lives", int'(lives), 0);
      check("t6_grow", int'(grow), 0);
      check("t6_playing", int'(playing), 0);
      tick();
      nRst = 1'b1;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
